move_sequencer: RTL and testbench

//  Front-end controller for the 2048 board engine. Debounces the four direction buttons,

---
 rtl/game_pkg.sv | 33 +++
 rtl/button_debounce.sv | 54 +++++
 rtl/move_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_move_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared command codes, FSM states and LFSR step for the move sequencer
package game_pkg;

  localparam int CMD_OP_W = 3;
  localparam int CELL_W   = 4;

  // Board engine command codes
  localparam logic [CMD_OP_W-1:0] OP_UP    = 3'd0;
  localparam logic [CMD_OP_W-1:0] OP_DOWN  = 3'd1;
  localparam logic [CMD_OP_W-1:0] OP_LEFT  = 3'd2;
  localparam logic [CMD_OP_W-1:0] OP_RIGHT = 3'd3;
  localparam logic [CMD_OP_W-1:0] OP_SPAWN = 3'd4;
  localparam logic [CMD_OP_W-1:0] OP_CLEAR = 3'd5;

  // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_CLR   = 3'd1,
    S_ISPN  = 3'd2,
    S_IDLE  = 3'd3,
    S_MOVE  = 3'd4,
    S_SPAWN = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  // One step of the spawn LFSR
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser, stable-level debouncer and press pulse for one button
module button_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Bring the raw asynchronous level into the clock domain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
    end
  end

  // Accept a new level once it has differed from the accepted one for DEBOUNCE_CYC samples;
  // only an accepted rising level produces a press pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync1 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= r_sync1;
        r_cnt    <= '0;
        r_press  <= r_sync1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - 2048 front-end: button arbitration, command FSM, spawn LFSR; optional MOVE_QUEUE_EN
module move_sequencer
  import game_pkg::*;
#(
  parameter int          DEBOUNCE_CYC = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                up,
  input  logic                down,
  input  logic                left,
  input  logic                right,
  input  logic                new_game,
  input  logic                game_over,
  output logic                cmd_valid,
  output logic [CMD_OP_W-1:0] cmd_op,
  output logic [CELL_W-1:0]   spawn_cell,
  output logic                spawn_four,
  input  logic                cmd_ack,
  input  logic                cmd_changed,
  output logic                busy,
  output logic [15:0]         move_count
);

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          w_press;
  logic                w_ev_any;
  logic [CMD_OP_W-1:0] w_ev_op;
  logic                w_ack;
  logic                w_busy;
  logic                w_take_queue;
  logic                w_q_valid;
  logic [CMD_OP_W-1:0] w_q_op;
  logic [15:0]         r_lfsr;
  logic [CMD_OP_W-1:0] r_cmd_op;
  logic [CELL_W-1:0]   r_spawn_cell;
  logic                r_spawn_four;
  logic [15:0]         r_move_count;
  logic                r_pend_new;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .i_clk(Clk), .i_rst(Reset), .i_btn(up), .o_press(w_press[0])
  );
  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
    .i_clk(Clk), .i_rst(Reset), .i_btn(down), .o_press(w_press[1])
  );
  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_left (
    .i_clk(Clk), .i_rst(Reset), .i_btn(left), .o_press(w_press[2])
  );
  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_right (
    .i_clk(Clk), .i_rst(Reset), .i_btn(right), .o_press(w_press[3])
  );

  // Fixed-priority arbitration of same-cycle presses: up > down > left > right
  always_comb begin
    w_ev_any = |w_press;
    w_ev_op  = OP_RIGHT;
    if (w_press[0])      w_ev_op = OP_UP;
    else if (w_press[1]) w_ev_op = OP_DOWN;
    else if (w_press[2]) w_ev_op = OP_LEFT;
  end

  assign cmd_valid = (r_state == S_CLR) || (r_state == S_ISPN) ||
                     (r_state == S_MOVE) || (r_state == S_SPAWN);
  assign w_busy    = (r_state != S_IDLE) && (r_state != S_HALT);
  assign w_ack     = cmd_ack && cmd_valid;

  // State register; reset lands in S_BOOT so cmd_valid drops immediately
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_BOOT;
    else       r_state <= w_state_next;
  end

  // Next-state decode; new_game outranks game_over, which outranks any move
  always_comb begin
    w_state_next = r_state;
    w_take_queue = 1'b0;
    unique case (r_state)
      S_BOOT:  w_state_next = S_CLR;
      S_CLR:   if (w_ack) w_state_next = S_ISPN;
      S_ISPN:  if (w_ack) w_state_next = S_IDLE;
      S_IDLE: begin
        if (r_pend_new) begin
          w_state_next = S_CLR;
        end else if (game_over) begin
          w_state_next = S_HALT;
        end else if (w_q_valid) begin
          w_state_next = S_MOVE;
          w_take_queue = 1'b1;
        end else if (w_ev_any) begin
          w_state_next = S_MOVE;
        end
      end
      S_MOVE:  if (w_ack) w_state_next = cmd_changed ? S_SPAWN : S_IDLE;
      S_SPAWN: if (w_ack) w_state_next = S_IDLE;
      S_HALT:  if (r_pend_new) w_state_next = S_CLR;
      default: w_state_next = S_BOOT;
    endcase
  end

  // Spawn LFSR free-runs every cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= lfsr_step(r_lfsr);
  end

  // Command fields are loaded on state entry and held until the next command
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cmd_op     <= OP_UP;
      r_spawn_cell <= '0;
      r_spawn_four <= 1'b0;
    end else if (w_state_next != r_state) begin
      case (w_state_next)
        S_CLR: r_cmd_op <= OP_CLEAR;
        S_ISPN, S_SPAWN: begin
          r_cmd_op     <= OP_SPAWN;
          r_spawn_cell <= r_lfsr[3:0];
          r_spawn_four <= (r_lfsr[7:4] == 4'd0);
        end
        S_MOVE: r_cmd_op <= w_take_queue ? w_q_op : w_ev_op;
        default: ;
      endcase
    end
  end

  // Count MOVE acks that changed the board; a completed CLEAR restarts the count
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_move_count <= '0;
    end else if (w_ack && (r_state == S_CLR)) begin
      r_move_count <= '0;
    end else if (w_ack && (r_state == S_MOVE) && cmd_changed) begin
      r_move_count <= r_move_count + 16'd1;
    end
  end

  // Remember a new_game request until the FSM reaches a point where it can restart
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pend_new <= 1'b0;
    end else if (new_game) begin
      r_pend_new <= 1'b1;
    end else if (w_state_next == S_CLR && r_state != S_BOOT) begin
      r_pend_new <= 1'b0;
    end
  end

`ifdef MOVE_QUEUE_EN
  logic                r_q_valid;
  logic [CMD_OP_W-1:0] r_q_op;

  // One-deep move queue: first press while busy is kept, later ones dropped
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_q_valid <= 1'b0;
      r_q_op    <= OP_UP;
    end else if (new_game || (w_state_next == S_HALT) || w_take_queue) begin
      r_q_valid <= 1'b0;
    end else if (w_ev_any && w_busy && !r_q_valid && !r_pend_new) begin
      r_q_valid <= 1'b1;
      r_q_op    <= w_ev_op;
    end
  end

  assign w_q_valid = r_q_valid;
  assign w_q_op    = r_q_op;
`else
  assign w_q_valid = 1'b0;
  assign w_q_op    = OP_UP;
`endif

  assign cmd_op     = r_cmd_op;
  assign spawn_cell = r_spawn_cell;
  assign spawn_four = r_spawn_four;
  assign busy       = w_busy;
  assign move_count = r_move_count;

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - directed self-checking bench for move_sequencer
module tb_move_sequencer;
  import game_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        up, down, left, right;
  logic        new_game, game_over;
  logic        cmd_ack, cmd_changed;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [3:0]  spawn_cell;
  logic        spawn_four;
  logic        busy;
  logic [15:0] move_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  always #5 Clk = ~Clk;

  move_sequencer #(.DEBOUNCE_CYC(16), .LFSR_SEED(16'hACE1)) dut (
    .Clk(Clk), .Reset(Reset), .up(up), .down(down), .left(left), .right(right),
    .new_game(new_game), .game_over(game_over), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .spawn_cell(spawn_cell), .spawn_four(spawn_four), .cmd_ack(cmd_ack),
    .cmd_changed(cmd_changed), .busy(busy), .move_count(move_count)
  );

  // Reference spawn LFSR; m_prev holds the value present just before the latest edge
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_lfsr = 16'hACE1;
      m_prev = 16'hACE1;
    end else begin
      m_prev = m_lfsr;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Engine model: wait for a command, check it, optionally ack after a delay
  task automatic do_cmd(input logic [2:0] exp_op, input logic chg, input int ack_delay,
                        input logic do_ack, input string name);
    int         waited;
    logic [3:0] exp_cell;
    logic       exp_four;
    waited = 0;
    while (cmd_valid !== 1'b1 && waited < 60) begin
      tick(1);
      waited++;
    end
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid got %b want 1 (timeout)", name, cmd_valid);
      return;
    end
    checks++;
    if (cmd_op !== exp_op) begin
      errors++;
      $display("FAIL %s_op got %0d want %0d", name, cmd_op, exp_op);
    end
    if (exp_op == OP_SPAWN) begin
      exp_cell = m_prev[3:0];
      exp_four = (m_prev[7:4] == 4'd0);
      checks++;
      if (spawn_cell !== exp_cell) begin
        errors++;
        $display("FAIL %s_cell got %0d want %0d", name, spawn_cell, exp_cell);
      end
      checks++;
      if (spawn_four !== exp_four) begin
        errors++;
        $display("FAIL %s_four got %b want %b", name, spawn_four, exp_four);
      end
    end
    if (do_ack) begin
      tick(ack_delay);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_op !== exp_op) begin
        errors++;
        $display("FAIL %s_hold got v=%b op=%0d want v=1 op=%0d", name, cmd_valid, cmd_op, exp_op);
      end
      cmd_ack     = 1'b1;
      cmd_changed = chg;
      tick(1);
      cmd_ack     = 1'b0;
      cmd_changed = 1'b0;
    end
  endtask

  task automatic expect_quiet(input int n, input string name);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      tick(1);
      if (cmd_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s got unexpected command op=%0d want none", name, cmd_op);
    end
  endtask

  task automatic check_val(input logic [15:0] got, input logic [15:0] want, input string name);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic test_reset;
    check_val({15'd0, cmd_valid}, 16'd0, "rst_cmd_valid");
    check_val({13'd0, cmd_op}, 16'd0, "rst_cmd_op");
    check_val({12'd0, spawn_cell}, 16'd0, "rst_spawn_cell");
    check_val({15'd0, spawn_four}, 16'd0, "rst_spawn_four");
    check_val({15'd0, busy}, 16'd1, "rst_busy");
    check_val(move_count, 16'd0, "rst_move_count");
    Reset = 1'b0;
    do_cmd(OP_CLEAR, 1'b0, 2, 1'b1, "boot_clear");
    do_cmd(OP_SPAWN, 1'b0, 2, 1'b1, "boot_spawn");
    check_val({15'd0, busy}, 16'd0, "boot_idle_busy");
    check_val(move_count, 16'd0, "boot_move_count");
  endtask

  task automatic test_debounce;
    up = 1'b1;
    do_cmd(OP_UP, 1'b0, 2, 1'b1, "deb_up");
    up = 1'b0;
    expect_quiet(40, "deb_single_event");
    check_val(move_count, 16'd0, "deb_unchanged_count");
    up = 1'b1;
    tick(5);
    up = 1'b0;
    expect_quiet(40, "deb_glitch");
  endtask

  task automatic test_arbitration;
    left  = 1'b1;
    right = 1'b1;
    do_cmd(OP_LEFT, 1'b1, 2, 1'b1, "arb_left");
    do_cmd(OP_SPAWN, 1'b0, 2, 1'b1, "arb_spawn");
    check_val(move_count, 16'd1, "arb_count_1");
    left  = 1'b0;
    right = 1'b0;
    expect_quiet(40, "arb_loser_dropped");
    left = 1'b1;
    do_cmd(OP_LEFT, 1'b0, 2, 1'b1, "nochg_left");
    left = 1'b0;
    expect_quiet(40, "nochg_no_spawn");
    check_val(move_count, 16'd1, "nochg_count");
    down  = 1'b1;
    right = 1'b1;
    do_cmd(OP_DOWN, 1'b0, 2, 1'b1, "arb_down");
    down  = 1'b0;
    right = 1'b0;
    expect_quiet(40, "arb_down_quiet");
  endtask

  task automatic test_busy_press;
    left = 1'b1;
    do_cmd(OP_LEFT, 1'b1, 2, 1'b1, "busy_left");
    left = 1'b0;
    down = 1'b1;
    do_cmd(OP_SPAWN, 1'b0, 30, 1'b1, "busy_spawn");
    check_val(move_count, 16'd2, "busy_count_2");
`ifdef MOVE_QUEUE_EN
    do_cmd(OP_DOWN, 1'b0, 2, 1'b1, "busy_queued_down");
`else
    expect_quiet(40, "busy_press_dropped");
`endif
    down = 1'b0;
    expect_quiet(40, "busy_after_quiet");
  endtask

  task automatic test_game_over;
    game_over = 1'b1;
    tick(2);
    check_val({15'd0, busy}, 16'd0, "halt_busy");
    check_val({15'd0, cmd_valid}, 16'd0, "halt_cmd_valid");
    up = 1'b1;
    tick(25);
    up = 1'b0;
    expect_quiet(40, "halt_press_ignored");
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    do_cmd(OP_CLEAR, 1'b0, 2, 1'b1, "ng_clear");
    game_over = 1'b0;
    check_val(move_count, 16'd0, "ng_count_cleared");
    do_cmd(OP_SPAWN, 1'b0, 2, 1'b1, "ng_spawn");
    check_val({15'd0, busy}, 16'd0, "ng_idle_busy");
  endtask

  task automatic test_reset_mid_cmd;
    right = 1'b1;
    do_cmd(OP_RIGHT, 1'b0, 0, 1'b0, "rmid_move");
    #1;
    Reset = 1'b1;
    right = 1'b0;
    #1;
    check_val({15'd0, cmd_valid}, 16'd0, "rmid_cmd_valid");
    check_val({15'd0, busy}, 16'd1, "rmid_busy");
    check_val({13'd0, cmd_op}, 16'd0, "rmid_cmd_op");
    check_val(dut.r_lfsr, 16'hACE1, "rmid_lfsr");
    tick(2);
    Reset = 1'b0;
    do_cmd(OP_CLEAR, 1'b0, 2, 1'b1, "rmid_clear");
    do_cmd(OP_SPAWN, 1'b0, 2, 1'b1, "rmid_spawn");
  endtask

  initial begin
    Reset       = 1'b1;
    up          = 1'b0;
    down        = 1'b0;
    left        = 1'b0;
    right       = 1'b0;
    new_game    = 1'b0;
    game_over   = 1'b0;
    cmd_ack     = 1'b0;
    cmd_changed = 1'b0;
    tick(2);
    test_reset();
    test_debounce();
    test_arbitration();
    test_busy_press();
    test_game_over();
    test_reset_mid_cmd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
